// File: rtl/ad_multi_ch_scheduler.sv
// ad_multi_ch_scheduler
//   Frame sequencer between the AD7606 driver and the voltage_cal/bcd/uart
//   chain. Every PERIOD cycles it freezes the most recent complete channel
//   set, walks the enabled channels in ascending order, starts the formatter
//   for each one and holds the UART write request until the transmitter
//   reports completion.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   ch_data         packed channel results, ch0 in the LSBs
//   ch_valid        one-cycle pulse: ch_data holds a new complete set
//   ch_mask         channel enable, sampled only at frame start
//   sel_data/sel_ch sample and index being formatted/sent
//   fmt_start       one-cycle formatter start pulse
//   fmt_done        formatter result stable (level or pulse)
//   tx_we / tx_end  UART write request / UART transfer complete
//   busy            high from frame start until frame end
//   frame_done      one-cycle pulse at frame end
//   fmt_err         sticky formatter-timeout flag, cleared only by rst
//   overrun_cnt     saturating count of period ticks dropped mid-frame
module ad_multi_ch_scheduler #(
  parameter int NUM_CH      = 8,
  parameter int DATA_W      = 16,
  parameter int CLK_FRE     = 50,
  parameter int SAMPLE_TIME = 20,
  parameter int FMT_TIMEOUT = 64,
  // Frame period in cycles; overridable so short periods can be exercised.
  parameter int PERIOD      = CLK_FRE * 1000 * SAMPLE_TIME
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     ch_valid,
  input  logic [NUM_CH-1:0]        ch_mask,
  output logic [DATA_W-1:0]        sel_data,
  output logic [2:0]               sel_ch,
  output logic                     fmt_start,
  input  logic                     fmt_done,
  output logic                     tx_we,
  input  logic                     tx_end,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     fmt_err,
  output logic [7:0]               overrun_cnt
);
  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TO_W  = (FMT_TIMEOUT > 1) ? $clog2(FMT_TIMEOUT) : 1;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // idx must be able to reach NUM_CH, the end-of-scan marker.
  localparam int IDX_W = $clog2(NUM_CH + 1);

  typedef enum logic [2:0] {IDLE, SCAN, FMT, TX, DONE} state_t;

  state_t                        state;
  logic [CNT_W-1:0]              cnt;
  logic                          tick;
  logic [TO_W-1:0]               wait_cnt;
  logic [IDX_W-1:0]              idx;
  logic [CH_W-1:0]               cur;
  logic [NUM_CH-1:0][DATA_W-1:0] shadow;
  logic [NUM_CH-1:0][DATA_W-1:0] latched;
  logic [NUM_CH-1:0]             latched_mask;

  assign tick = (cnt == CNT_W'(PERIOD - 1));
  assign cur  = idx[CH_W-1:0];

  // Free-running frame period counter.
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CNT_W'(1);
  end

  // Shadow copy of the latest complete set; a frame works from its own
  // latched copy so ch_valid mid-frame cannot disturb the data being sent.
  always_ff @(posedge clk) begin
    if (rst)           shadow <= '0;
    else if (ch_valid) shadow <= ch_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      wait_cnt     <= '0;
      latched      <= '0;
      latched_mask <= '0;
      sel_data     <= '0;
      sel_ch       <= '0;
      fmt_start    <= 1'b0;
      tx_we        <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      fmt_err      <= 1'b0;
      overrun_cnt  <= '0;
    end else begin
      fmt_start  <= 1'b0;
      frame_done <= 1'b0;

      // A tick that lands mid-frame is dropped and only counted.
      if (tick && state != IDLE && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;

      unique case (state)
        IDLE: begin
          if (tick && ch_mask != '0) begin
            latched      <= shadow;
            latched_mask <= ch_mask;
            idx          <= '0;
            busy         <= 1'b1;
            state        <= SCAN;
          end
        end
        SCAN: begin
          if (idx == IDX_W'(NUM_CH)) begin
            state <= DONE;
          end else if (latched_mask[cur]) begin
            sel_ch    <= 3'(cur);
            sel_data  <= latched[cur];
            fmt_start <= 1'b1;
            wait_cnt  <= '0;
            state     <= FMT;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        FMT: begin
          if (fmt_done) begin
            state <= TX;
          end else if (wait_cnt == TO_W'(FMT_TIMEOUT - 1)) begin
            // Formatter stalled: flag it and skip this channel unsent.
            fmt_err <= 1'b1;
            idx     <= idx + IDX_W'(1);
            state   <= SCAN;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
        end
        TX: begin
          // tx_end already high on entry completes without raising tx_we.
          if (tx_end) begin
            tx_we <= 1'b0;
            idx   <= idx + IDX_W'(1);
            state <= SCAN;
          end else begin
            tx_we <= 1'b1;
          end
        end
        DONE: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
